// File: rtl/sc_pkg.sv
// Shared types, widths and the stream-length decode for the stochastic job sequencer.
package sc_pkg;

    localparam int unsigned CNT_W  = 9;
    localparam int unsigned LEN_W  = 3;
    localparam int unsigned NIB_W  = 4;
    localparam int unsigned LFSR_W = 31;

    typedef enum logic [1:0] {
        IDLE,
        LOAD,
        RUN,
        DONE
    } state_e;

    typedef struct packed {
        logic [NIB_W-1:0] a;
        logic [NIB_W-1:0] b;
        logic [LEN_W-1:0] len;
    } job_t;

    // Codes 0..4 give 16 << code; every larger code saturates at 256.
    function automatic logic [CNT_W-1:0] len_decode(input logic [LEN_W-1:0] code);
        if (code >= LEN_W'(4)) begin
            return CNT_W'(256);
        end
        return CNT_W'(16) << code;
    endfunction

endpackage

// File: rtl/stochastic_job_sequencer_if.sv
// Job request / result handshake bundle between a job source and the sequencer.
interface stochastic_job_sequencer_if;
    import sc_pkg::*;

    logic              req_valid;
    logic              req_ready;
    logic [NIB_W-1:0]  req_a;
    logic [NIB_W-1:0]  req_b;
    logic [LEN_W-1:0]  req_len;
    logic              abort;
    logic              res_valid;
    logic              res_ready;
    logic [CNT_W-1:0]  res_count;
    logic [LEN_W-1:0]  res_len;
    logic              busy;

    modport master (
        output req_valid, req_a, req_b, req_len, abort, res_ready,
        input  req_ready, res_valid, res_count, res_len, busy
    );

    modport slave (
        input  req_valid, req_a, req_b, req_len, abort, res_ready,
        output req_ready, res_valid, res_count, res_len, busy
    );

endinterface

// File: rtl/sc_lfsr31.sv
// 31-bit Fibonacci LFSR, x^31 + x^28 + 1, with synchronous seed reload.
module sc_lfsr31
    import sc_pkg::*;
(
    input  logic              clk,
    input  logic              load,
    input  logic              en,
    input  logic [LFSR_W-1:0] seed,
    output logic [LFSR_W-1:0] state
);

    logic [LFSR_W-1:0] state_q;

    always_ff @(posedge clk) begin
        if (load) begin
            state_q <= seed;
        end else if (en) begin
            state_q <= {state_q[LFSR_W-2:0], state_q[30] ^ state_q[27]};
        end
    end

    assign state = state_q;

endmodule

// File: rtl/stochastic_job_sequencer.sv
// Runs one stochastic-computing multiply job: two LFSR-driven bitstreams are XNORed
// and the ones in the product stream are counted over a selectable stream length.
module stochastic_job_sequencer
    import sc_pkg::*;
#(
    parameter logic [LFSR_W-1:0] SEED_A = 31'd1,
    parameter logic [LFSR_W-1:0] SEED_B = 31'd2
) (
    input  logic                       clk,
    input  logic                       rst_n,
    stochastic_job_sequencer_if.slave  bus
);

    state_e            state_q, state_d;
    job_t              job_q, job_d;
    logic [CNT_W-1:0]  bit_cnt_q, bit_cnt_d;
    logic [CNT_W-1:0]  ones_q, ones_d;
    logic [CNT_W-1:0]  res_count_q, res_count_d;
    logic [LEN_W-1:0]  res_len_q, res_len_d;
    logic              req_ready_q, req_ready_d;
    logic              res_valid_q, res_valid_d;
    logic              busy_q, busy_d;

    logic [LFSR_W-1:0] lfsr_a, lfsr_b;
    logic              lfsr_load_c, lfsr_en_c;
    logic              bit_a_c, bit_b_c, prod_c, last_c;
    logic [CNT_W-1:0]  len_c;
    logic              unused_lfsr_hi;

    sc_lfsr31 u_lfsr_a (
        .clk   (clk),
        .load  (lfsr_load_c | rst_n),
        .en    (lfsr_en_c),
        .seed  (SEED_A),
        .state (lfsr_a)
    );

    sc_lfsr31 u_lfsr_b (
        .clk   (clk),
        .load  (lfsr_load_c | rst_n),
        .en    (lfsr_en_c),
        .seed  (SEED_B),
        .state (lfsr_b)
    );

    // Only the low nibble is compared; the upper bits just feed the shift chain.
    assign unused_lfsr_hi = ^{lfsr_a[LFSR_W-1:NIB_W], lfsr_b[LFSR_W-1:NIB_W]};

    always_comb begin
        state_d     = state_q;
        job_d       = job_q;
        bit_cnt_d   = bit_cnt_q;
        ones_d      = ones_q;
        res_count_d = res_count_q;
        res_len_d   = res_len_q;
        lfsr_load_c = 1'b0;
        lfsr_en_c   = 1'b0;

        bit_a_c = (lfsr_a[NIB_W-1:0] < job_q.a);
        bit_b_c = (lfsr_b[NIB_W-1:0] < job_q.b);
        prod_c  = ~(bit_a_c ^ bit_b_c);
        len_c   = len_decode(job_q.len);
        last_c  = (bit_cnt_q == len_c - CNT_W'(1));

        unique case (state_q)
            IDLE: begin
                if (bus.req_valid && req_ready_q) begin
                    job_d   = '{a: bus.req_a, b: bus.req_b, len: bus.req_len};
                    state_d = LOAD;
                end
            end
            LOAD: begin
                lfsr_load_c = 1'b1;
                bit_cnt_d   = '0;
                ones_d      = '0;
                state_d     = bus.abort ? IDLE : RUN;
            end
            RUN: begin
                // Abort outranks completion of the final stream bit.
                if (bus.abort) begin
                    state_d = IDLE;
                end else begin
                    lfsr_en_c = 1'b1;
                    ones_d    = ones_q + CNT_W'(prod_c);
                    bit_cnt_d = bit_cnt_q + CNT_W'(1);
                    if (last_c) begin
                        res_count_d = ones_d;
                        res_len_d   = job_q.len;
                        state_d     = DONE;
                    end
                end
            end
            DONE: begin
                if (bus.res_ready) begin
                    state_d = IDLE;
                end
            end
            default: state_d = IDLE;
        endcase

        req_ready_d = (state_d == IDLE);
        res_valid_d = (state_d == DONE);
        busy_d      = (state_d != IDLE);
    end

    always_ff @(posedge clk) begin
        if (rst_n) begin
            state_q     <= IDLE;
            job_q       <= '0;
            bit_cnt_q   <= '0;
            ones_q      <= '0;
            res_count_q <= '0;
            res_len_q   <= '0;
            req_ready_q <= 1'b0;
            res_valid_q <= 1'b0;
            busy_q      <= 1'b0;
        end else begin
            state_q     <= state_d;
            job_q       <= job_d;
            bit_cnt_q   <= bit_cnt_d;
            ones_q      <= ones_d;
            res_count_q <= res_count_d;
            res_len_q   <= res_len_d;
            req_ready_q <= req_ready_d;
            res_valid_q <= res_valid_d;
            busy_q      <= busy_d;
        end
    end

    assign bus.req_ready = req_ready_q;
    assign bus.res_valid = res_valid_q;
    assign bus.res_count = res_count_q;
    assign bus.res_len   = res_len_q;
    assign bus.busy      = busy_q;

endmodule

// File: doc/stochastic_job_sequencer.md
STOCHASTIC_JOB_SEQUENCER -- requirements
Module: stochastic_job_sequencer

Interface
REQ-001 SHALL have parameter SEED_A, default 31'd1: reload value of operand-A LFSR at job start.
REQ-002 SHALL have parameter SEED_B, default 31'd2: reload value of operand-B LFSR at job start; SEED_A and SEED_B SHALL be nonzero.
REQ-003 clk  input  1  single clock; all state updates on rising edge.
REQ-004 rst_n  input  1  reset, synchronous, active-high (1 = reset).
REQ-005 req_valid  input  1  job request present.
REQ-006 req_ready  output  1  sequencer can accept a job.
REQ-007 req_a  input  4  operand A probability nibble.
REQ-008 req_b  input  4  operand B probability nibble.
REQ-009 req_len  input  3  stream-length code.
REQ-010 abort  input  1  cancel current job.
REQ-011 res_valid  output  1  result available.
REQ-012 res_ready  input  1  result consumer ready.
REQ-013 res_count  output  9  number of 1s in product stream.
REQ-014 res_len  output  3  stream-length code of the completed job.
REQ-015 busy  output  1  high in any state except IDLE.

Function
REQ-016 FSM SHALL have states IDLE, LOAD, RUN, DONE.
REQ-017 req_ready SHALL be 1 only in IDLE; transfer occurs on req_valid && req_ready; req_a, req_b, req_len captured on that edge; IDLE -> LOAD.
REQ-018 Stream length L SHALL be 16 << req_len for codes 0..4 (16,32,64,128,256); codes 5..7 SHALL decode to 256; res_len reports the captured code unmodified.
REQ-019 LOAD (exactly 1 cycle): both LFSRs reloaded to SEED_A/SEED_B, bit counter and ones counter cleared; LOAD -> RUN.
REQ-020 Each LFSR SHALL be 31-bit, x^31+x^28+1: next = {s[29:0], s[30]^s[27]}, advancing once per RUN cycle.
REQ-021 Each RUN cycle: bit_a = (lfsr_a[3:0] < a), bit_b = (lfsr_b[3:0] < b), product = XNOR(bit_a, bit_b), unsigned 4-bit compare, evaluated on current (pre-advance) LFSR state; product added to ones counter same edge.
REQ-022 RUN SHALL last exactly L cycles, then -> DONE; ones counter 9 bits, max 256, no overflow possible.
REQ-023 Latency: job accepted at edge T -> res_valid first high in cycle T+2+L.
REQ-024 DONE: res_valid=1, res_count and res_len stable until res_valid && res_ready; then -> IDLE, res_valid=0 next cycle.
REQ-025 req_valid while not IDLE SHALL be ignored (no capture, no queueing).
REQ-026 abort in LOAD or RUN SHALL go to IDLE next edge, no res_valid, res_count unchanged from previous result.
REQ-027 abort in DONE or IDLE SHALL be ignored.
REQ-028 abort and completion of final RUN cycle on same edge: abort wins.
REQ-029 res_count/res_len SHALL hold last delivered value while IDLE/LOAD/RUN.

Reset
REQ-030 rst_n=1 at any edge, any state: state=IDLE, res_valid=0, res_count=0, res_len=0, busy=0, LFSRs=SEED_A/SEED_B, counters=0.
REQ-031 req_ready SHALL be 0 while rst_n=1 and 1 in first cycle after release.

Structure
REQ-032 Package sc_pkg SHALL hold FSM state enum, CNT_W=9, LEN_W=3, and length-decode function.
REQ-033 One sub-module sc_lfsr31 (ports: clk, load, en, seed[30:0], state[30:0]) SHALL be instantiated twice.

Verification
REQ-034 Reset release, req_a=0, req_b=0, req_len=0 at T -> res_valid at T+18, res_count=16, res_len=0.
REQ-035 req_a=0, req_b=0, req_len=7 -> res_count=256, res_valid at T+258, res_len=7.
REQ-036 req_a=15, req_b=8, req_len=2 -> res_count equals bit-accurate model of REQ-020/021 with seeds 1/2.
REQ-037 abort asserted 5 cycles into RUN -> IDLE next cycle, no res_valid, req_ready=1, prior res_count held.
REQ-038 res_ready low 6 cycles in DONE -> res_valid, res_count stable; req_valid pulses ignored; accepted after handshake.
REQ-039 rst_n pulsed mid-RUN -> all outputs 0 next cycle; new job afterward gives same result as from cold reset.
